keypad_scan_module: RTL and testbench
=====================================

// Module: keypad_scan_module
// PURPOSE
//  4x4 matrix keypad scanner and debouncer feeding the game module's keypad_input/keypad_enable.
//  - Drives one row low at a time and samples the active-low columns.
//  - Debounces the pressed key and outputs a stable note code 1..15 plus a held-level enable.
//  - Sits between the board keypad pins and the game logic. Replaces the raw, bouncy keypad strobe.
// PARAMETERS
//  SCAN_DIV      50000  clocks per scan tick (1 ms at 50 MHz); must be >= 4
//  DEBOUNCE_CNT  20     consecutive agreeing ticks needed to accept a press or a release; >= 1
// PORTS
//  clk           in   1  system clock; single clock domain
//  reset         in   1  synchronous, active-high reset
//  key_col       in   4  column inputs, active-low (board pull-ups); asynchronous to clk
//  key_row       out  4  row drive, active-low, exactly one bit low at all times
//  key_code      out  4  debounced code = row*4+col+1 while key_enable=1, else 0
//  key_enable    out  1  high for the whole time a debounced key is held
//  key_press     out  1  1-cycle pulse on the cycle key_enable rises
// BEHAVIOUR
//  Reset (sync, active-high):
//   - key_row=4'b1110, key_code=0, key_enable=0, key_press=0.
//   - state=SCAN, tick counter=0, debounce count=0, synchronizer flops=4'b1111.
//   - Reset mid-DEBOUNCE or mid-PRESSED aborts at once; outputs are 0 on the next edge.
//  Input synchronization: key_col passes a 2-flop synchronizer; all logic uses the synced value.
//  Tick: free-running counter 0..SCAN_DIV-1; tick=1 for one cycle when it reaches SCAN_DIV-1, then wraps to 0.
//  States:
//   SCAN
//    - On tick, sample synced columns for the currently driven row.
//    - Exactly one column low and index!=15: latch row/col, set cnt=1, go to DEBOUNCE, hold key_row.
//    - Otherwise (none low, more than one low, or index 15): rotate key_row left (1110->1101->1011->0111->1110).
//   DEBOUNCE
//    - Row frozen. On each tick:
//      - Only the latched column low: cnt++.
//      - Any other pattern: go to SCAN and resume rotation from the latched row.
//    - cnt reaches DEBOUNCE_CNT: go to PRESSED.
//      - Same edge: key_enable=1, key_code=index+1, key_press=1 for exactly one cycle.
//   PRESSED
//    - Row frozen. Only the latched column is watched; other keys are ignored.
//    - On tick: latched column high -> rcnt++; latched column low -> rcnt=0.
//    - rcnt reaches DEBOUNCE_CNT: go to SCAN.
//      - Same edge: key_enable=0 and key_code=0.
//  Latency:
//   - Press accepted after at most (4+DEBOUNCE_CNT)*SCAN_DIV+2 clocks.
//   - Release accepted DEBOUNCE_CNT ticks (+2 sync clocks) after the column goes stably high.
//  Rules:
//   - key_code is stable for the whole time key_enable=1.
//   - key_press never fires twice without an accepted release in between.
//   - Index 15 (row3,col3) is never reported (code 0 is reserved for "no key").
//   - key_row changes only on a tick edge.
//  Width rules:
//   - Tick counter width = $clog2(SCAN_DIV).
//   - Debounce counters width = $clog2(DEBOUNCE_CNT+1); they saturate and never wrap.
// STRUCTURE
//  - Package keypad_pkg holds:
//    - state encoding SCAN/DEBOUNCE/PRESSED (2-bit typedef);
//    - NUM_ROWS=4, NUM_COLS=4;
//    - KEY_NONE=4'd0 and KEY_RESERVED_IDX=4'd15;
//    - ROW_IDLE=4'b1110.
//  - One sub-module: scan_tick_gen (parameter DIV; ports clk, reset, tick), the divider counter.
//  - Synchronizer, FSM and row rotation stay in this module.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_CNT=3; the keypad model pulls col low only while its row is driven)
//  1 Reset: assert reset 2 cycles -> key_row=1110, key_code=0, key_enable=0, key_press=0; tick after 4 clocks.
//  2 Clean press row1,col2: held 200 clocks -> single key_press pulse, key_enable=1, key_code=7;
//    release -> key_enable=0 and key_code=0 within 3 ticks+2 clocks.
//  3 Bounce: row0,col0 toggles every tick for 10 ticks, then held -> no key_enable during bounce;
//    code 1 accepted 3 ticks after stable.
//  4 Ghost: row2 cols 0 and 1 both low -> key_row keeps rotating, key_enable stays 0.
//  5 Reserved: row3,col3 held 200 clocks -> key_enable never rises; row3,col2 then gives code 15.
//  6 Reset mid-PRESSED (code 7 held): reset 1 cycle -> next edge all outputs 0, key_row=1110;
//    key still held -> re-accepted with a fresh key_press.

Source files
------------

// File: rtl/keypad_scan_module_pkg.sv
// Shared constants, state encoding and column-decode helpers for the keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [3:0] KEY_NONE         = 4'd0;
    localparam logic [3:0] KEY_RESERVED_IDX = 4'd15;
    localparam logic [3:0] ROW_IDLE         = 4'b1110;

    typedef logic [1:0] state_t;
    localparam state_t ST_SCAN     = 2'd0;
    localparam state_t ST_DEBOUNCE = 2'd1;
    localparam state_t ST_PRESSED  = 2'd2;

    function automatic logic col_one_low(input logic [NUM_COLS-1:0] col);
        return ($countones(~col) == 1);
    endfunction

    // Index of the lowest active-low column; only meaningful when exactly one is low.
    function automatic logic [1:0] col_low_index(input logic [NUM_COLS-1:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        if (!col[0])      idx = 2'd0;
        else if (!col[1]) idx = 2'd1;
        else if (!col[2]) idx = 2'd2;
        else if (!col[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_module_if.sv
// Keypad pin and game-side key signals; the scanner takes the master view.
interface keypad_if;
    import keypad_pkg::*;

    logic [NUM_COLS-1:0] key_col;
    logic [NUM_ROWS-1:0] key_row;
    logic [3:0]          key_code;
    logic                key_enable;
    logic                key_press;

    modport master (
        input  key_col,
        output key_row,
        output key_code,
        output key_enable,
        output key_press
    );

    modport slave (
        output key_col,
        input  key_row,
        input  key_code,
        input  key_enable,
        input  key_press
    );
endinterface

// File: rtl/keypad_scan_module_scan_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks.
module scan_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/keypad_scan_module.sv
// 4x4 keypad scanner/debouncer producing a held note code 1..15 with enable and press pulse.
//  state    | meaning
//  SCAN     | rotating rows, looking for a single low column
//  DEBOUNCE | row frozen, counting ticks the latched column stays the only low one
//  PRESSED  | key reported, counting ticks the latched column stays high
module keypad_scan_module
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic     clk,
    input  logic     reset,
    keypad_if.master kp
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic                tick;
    logic [NUM_COLS-1:0] col_meta;
    logic [NUM_COLS-1:0] col_sync;
    state_t              state;
    logic [1:0]          row_idx;
    logic [1:0]          col_idx;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       rcnt;
    logic [CW-1:0]       cnt_inc;
    logic [CW-1:0]       rcnt_inc;
    logic [3:0]          scan_idx;
    logic                scan_hit;
    logic                latched_low_only;
    logic                latched_high;

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= kp.key_col;
            col_sync <= col_meta;
        end
    end

    always_comb begin
        scan_idx         = {row_idx, col_low_index(col_sync)};
        scan_hit         = col_one_low(col_sync) && (scan_idx != KEY_RESERVED_IDX);
        latched_low_only = (col_sync == ~(4'b0001 << col_idx));
        latched_high     = col_sync[col_idx];
        cnt_inc          = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        rcnt_inc         = (rcnt == CNT_MAX) ? rcnt : rcnt + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_SCAN;
            kp.key_row    <= ROW_IDLE;
            row_idx       <= 2'd0;
            col_idx       <= 2'd0;
            cnt           <= '0;
            rcnt          <= '0;
            kp.key_code   <= KEY_NONE;
            kp.key_enable <= 1'b0;
            kp.key_press  <= 1'b0;
        end else begin
            kp.key_press <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (scan_hit) begin
                            col_idx <= col_low_index(col_sync);
                            cnt     <= CNT_ONE;
                            rcnt    <= '0;
                            // A single-tick debounce accepts on the very first sample.
                            if (CNT_ONE == CNT_MAX) begin
                                state         <= ST_PRESSED;
                                kp.key_enable <= 1'b1;
                                kp.key_code   <= scan_idx + 4'd1;
                                kp.key_press  <= 1'b1;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end else begin
                            kp.key_row <= {kp.key_row[2:0], kp.key_row[3]};
                            row_idx    <= row_idx + 2'd1;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (latched_low_only) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_MAX) begin
                                state         <= ST_PRESSED;
                                rcnt          <= '0;
                                kp.key_enable <= 1'b1;
                                kp.key_code   <= {row_idx, col_idx} + 4'd1;
                                kp.key_press  <= 1'b1;
                            end
                        end else begin
                            state      <= ST_SCAN;
                            cnt        <= '0;
                            kp.key_row <= {kp.key_row[2:0], kp.key_row[3]};
                            row_idx    <= row_idx + 2'd1;
                        end
                    end
                    ST_PRESSED: begin
                        if (latched_high) begin
                            rcnt <= rcnt_inc;
                            if (rcnt_inc == CNT_MAX) begin
                                state         <= ST_SCAN;
                                cnt           <= '0;
                                rcnt          <= '0;
                                kp.key_enable <= 1'b0;
                                kp.key_code   <= KEY_NONE;
                            end
                        end else begin
                            rcnt <= '0;
                        end
                    end
                    default: begin
                        state <= ST_SCAN;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan_module.sv
// Directed bench for keypad_scan_module with SCAN_DIV=4, DEBOUNCE_CNT=3 and a matrix keypad model.
module tb_keypad_scan_module;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pressed;
    logic [3:0]  col_v;

    int checks = 0;
    int errors = 0;
    int press_cnt = 0;
    int en_seen = 0;
    int code_bad = 0;
    int rot_cnt = 0;
    logic [3:0] exp_code = 4'd0;
    logic [3:0] last_row;
    logic       ok;

    always #5 clk = ~clk;

    keypad_if kp ();

    // A key pulls its column low only while its row is being driven.
    always_comb begin
        col_v = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.key_row[r]) col_v[c] = 1'b0;
    end
    assign kp.key_col = col_v;

    keypad_scan_module #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        last_row = kp.key_row;
        @(posedge clk);
        #1;
        if (kp.key_press) press_cnt++;
        if (kp.key_enable) en_seen++;
        if (kp.key_enable && kp.key_code != exp_code) code_bad++;
        if (kp.key_row != last_row) rot_cnt++;
    endtask

    task automatic wait_enable(input logic lvl, input int budget, output logic hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (kp.key_enable == lvl) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        pressed = '0;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_row", kp.key_row, 4'b1110);
        check("rst_code", kp.key_code, 4'd0);
        check("rst_en", kp.key_enable, 1'b0);
        check("rst_press", kp.key_press, 1'b0);
        step(); step(); step();
        check("tick_pre_row", kp.key_row, 4'b1110);
        step();
        check("tick_row", kp.key_row, 4'b1101);

        // clean press row1,col2 -> code 7
        exp_code = 4'd7; press_cnt = 0; code_bad = 0;
        pressed[6] = 1'b1;
        for (int i = 0; i < 200; i++) step();
        check("clean_press_cnt", press_cnt, 1);
        check("clean_en", kp.key_enable, 1'b1);
        check("clean_code", kp.key_code, 4'd7);
        check("clean_code_stable", code_bad, 0);
        pressed = '0;
        wait_enable(1'b0, 20, ok);
        check("clean_release_to", ok, 1'b1);
        check("clean_rel_code", kp.key_code, 4'd0);

        // bounce on row0,col0 for 10 ticks, then held
        en_seen = 0; exp_code = 4'd1;
        for (int i = 0; i < 10; i++) begin
            pressed[0] = (i % 2 == 0);
            for (int k = 0; k < 4; k++) step();
        end
        check("bounce_no_en", en_seen, 0);
        pressed[0] = 1'b1;
        wait_enable(1'b1, 40, ok);
        check("bounce_accept_to", ok, 1'b1);
        check("bounce_code", kp.key_code, 4'd1);
        pressed = '0;
        wait_enable(1'b0, 20, ok);
        check("bounce_release_to", ok, 1'b1);

        // ghost: row2 cols 0 and 1 together
        en_seen = 0; rot_cnt = 0;
        pressed[8] = 1'b1; pressed[9] = 1'b1;
        for (int i = 0; i < 100; i++) step();
        check("ghost_no_en", en_seen, 0);
        check("ghost_rotating", (rot_cnt >= 20), 1'b1);
        pressed = '0;
        for (int i = 0; i < 8; i++) step();

        // reserved row3,col3 never reported; row3,col2 gives 15
        en_seen = 0;
        pressed[15] = 1'b1;
        for (int i = 0; i < 200; i++) step();
        check("reserved_no_en", en_seen, 0);
        check("reserved_code", kp.key_code, 4'd0);
        pressed = '0;
        exp_code = 4'd15;
        pressed[14] = 1'b1;
        wait_enable(1'b1, 40, ok);
        check("code15_to", ok, 1'b1);
        check("code15", kp.key_code, 4'd15);
        pressed = '0;
        wait_enable(1'b0, 20, ok);
        check("code15_release_to", ok, 1'b1);

        // reset while a key is held in PRESSED
        exp_code = 4'd7;
        pressed[6] = 1'b1;
        wait_enable(1'b1, 40, ok);
        check("mid_accept_to", ok, 1'b1);
        for (int i = 0; i < 6; i++) step();
        press_cnt = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_en", kp.key_enable, 1'b0);
        check("mid_rst_code", kp.key_code, 4'd0);
        check("mid_rst_press", kp.key_press, 1'b0);
        check("mid_rst_row", kp.key_row, 4'b1110);
        wait_enable(1'b1, 40, ok);
        check("mid_reaccept_to", ok, 1'b1);
        check("mid_reaccept_code", kp.key_code, 4'd7);
        step();
        check("mid_reaccept_press", press_cnt, 1);
        pressed = '0;
        wait_enable(1'b0, 20, ok);
        check("mid_release_to", ok, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
